// File: rtl/conv_pkg.sv
// Shared types and helpers for the 2-D convolution sequencer.
package conv_pkg;

  localparam int unsigned DIM_W_DEF  = 8;
  localparam int unsigned ADDR_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RUN,
    ST_DRAIN,
    ST_SAVE,
    ST_DONE
  } conv_state_e;

  // Row-major linear address. The caller truncates the result to its address width.
  function automatic logic [31:0] tap_addr(input logic [31:0] row,
                                           input logic [31:0] col,
                                           input logic [31:0] stride);
    return row * stride + col;
  endfunction

endpackage

// File: rtl/conv_tap_counter.sv
// Nested kernel-tap counters: n runs fastest, m advances when n wraps.
module conv_tap_counter
  import conv_pkg::*;
#(
  parameter int unsigned DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_step,
  input  logic [DIM_W-1:0] i_kw,
  input  logic [DIM_W-1:0] i_kh,
  output logic [DIM_W-1:0] o_n,
  output logic [DIM_W-1:0] o_m,
  output logic             o_first_tap,
  output logic             o_last_tap
);

  logic [DIM_W-1:0] r_n;
  logic [DIM_W-1:0] r_m;
  logic             w_n_wrap;
  logic             w_m_wrap;

  assign w_n_wrap = (r_n == i_kw - DIM_W'(1));
  assign w_m_wrap = (r_m == i_kh - DIM_W'(1));

  // After the last tap both counters return to zero, ready for the next window.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_n <= '0;
      r_m <= '0;
    end else if (i_step) begin
      if (w_n_wrap) begin
        r_n <= '0;
        r_m <= w_m_wrap ? '0 : r_m + DIM_W'(1);
      end else begin
        r_n <= r_n + DIM_W'(1);
      end
    end
  end

  assign o_n         = r_n;
  assign o_m         = r_m;
  assign o_first_tap = (r_n == '0) && (r_m == '0);
  assign o_last_tap  = w_n_wrap && w_m_wrap;

endmodule

// File: rtl/conv_sequencer.sv
// Control FSM for one 2-D valid convolution pass: taps, MAC drain, and result handoff.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned DIM_W   = DIM_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_img_w,
  input  logic [DIM_W-1:0]  cfg_img_h,
  input  logic [DIM_W-1:0]  cfg_ker_w,
  input  logic [DIM_W-1:0]  cfg_ker_h,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              tap_valid,
  output logic [ADDR_W-1:0] img_addr,
  output logic [ADDR_W-1:0] ker_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              save_valid,
  input  logic              save_ready,
  output logic [DIM_W-1:0]  out_row,
  output logic [DIM_W-1:0]  out_col
);

  localparam int unsigned DRW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  conv_state_e      r_state;
  conv_state_e      w_next;
  logic [DIM_W-1:0] r_iw, r_ih, r_kw, r_kh;
  logic [DIM_W-1:0] r_row, r_col;
  logic [DRW-1:0]   r_drain;

  logic [DIM_W-1:0] w_n, w_m;
  logic             w_first_tap, w_last_tap;
  logic             w_cfg_bad;
  logic             w_last_col, w_last_win;
  logic             w_xfer;

  conv_tap_counter #(.DIM_W(DIM_W)) u_taps (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (r_state == ST_CHECK),
    .i_step      (r_state == ST_RUN),
    .i_kw        (r_kw),
    .i_kh        (r_kh),
    .o_n         (w_n),
    .o_m         (w_m),
    .o_first_tap (w_first_tap),
    .o_last_tap  (w_last_tap)
  );

  assign w_cfg_bad  = (r_kw == '0) || (r_kh == '0) || (r_kw > r_iw) || (r_kh > r_ih);
  // OW-1 = IW-KW and OH-1 = IH-KH; comparing against these avoids the +1 overflow.
  assign w_last_col = (r_col == r_iw - r_kw);
  assign w_last_win = w_last_col && (r_row == r_ih - r_kh);
  assign w_xfer     = (r_state == ST_SAVE) && save_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_iw    <= '0;
      r_ih    <= '0;
      r_kw    <= '0;
      r_kh    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_next;
      r_drain <= (r_state == ST_DRAIN) ? r_drain + DRW'(1) : '0;
      if (r_state == ST_IDLE && start) begin
        r_iw <= cfg_img_w;
        r_ih <= cfg_img_h;
        r_kw <= cfg_ker_w;
        r_kh <= cfg_ker_h;
      end
      if (r_state == ST_CHECK) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_xfer) begin
        if (w_last_win) begin
          r_row <= '0;
          r_col <= '0;
        end else if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + DIM_W'(1);
        end else begin
          r_col <= r_col + DIM_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    cfg_err    = 1'b0;
    tap_valid  = 1'b0;
    save_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        busy = 1'b1;
        if (w_cfg_bad) begin
          cfg_err = 1'b1;
          w_next  = ST_IDLE;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy      = 1'b1;
        tap_valid = 1'b1;
        if (w_last_tap) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (r_drain == DRW'(MAC_LAT - 1)) w_next = ST_SAVE;
      end
      ST_SAVE: begin
        busy       = 1'b1;
        save_valid = 1'b1;
        if (save_ready) w_next = w_last_win ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    img_addr = '0;
    ker_addr = '0;
    if (tap_valid) begin
      img_addr = ADDR_W'(tap_addr(32'(r_row) + 32'(w_m), 32'(r_col) + 32'(w_n), 32'(r_iw)));
      ker_addr = ADDR_W'(tap_addr(32'(w_m), 32'(w_n), 32'(r_kw)));
    end
  end

  assign acc_en  = tap_valid;
  assign acc_clr = tap_valid && w_first_tap;
  assign out_row = r_row;
  assign out_col = r_col;

endmodule
